// File: rtl/dmac_ctrl_fsm.sv
// DMAC control FSM: latches a peripheral request, reads three config words over AHB,
// validates the control word, arms one channel and acks on completion.
// Optional build macro DMAC_CTRL_HRESP_ABORT_EN: abort the config fetch on an AHB ERROR response.
module dmac_ctrl_fsm #(
  parameter logic [1:0] HTRANS_IDLE   = 2'b00,
  parameter logic [1:0] HTRANS_NONSEQ = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] DmacReq,
  input  logic       HReady,
  input  logic [1:0] M_HResp,
  input  logic       bus_grant,
  input  logic       C_config,
  input  logic       irq,
  output logic       DmacReq_Reg_en,
  output logic       SAddr_Reg_en,
  output logic       DAddr_Reg_en,
  output logic       Trans_sz_Reg_en,
  output logic       Ctrl_Reg_en,
  output logic [1:0] addr_inc_sel,
  output logic [1:0] config_HTrans,
  output logic       config_write,
  output logic       con_en,
  output logic [1:0] con_sel,
  output logic       channel_en_1,
  output logic       channel_en_2,
  output logic       bus_req,
  output logic [1:0] dmac_ack,
  output logic       busy,
  output logic       cfg_err
);

  localparam int unsigned StateW = 4;

  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] SEL_CH1     = 2'b00;
  localparam logic [1:0] SEL_CH2     = 2'b01;
  localparam logic [1:0] SEL_CFG     = 2'b10;
  localparam logic [1:0] OFS_DADDR   = 2'b00;
  localparam logic [1:0] OFS_SIZE    = 2'b01;
  localparam logic [1:0] OFS_CTRL    = 2'b10;

  typedef enum logic [StateW-1:0] {
    IDLE     = 4'd0,
    LATCH    = 4'd1,
    GNT_WAIT = 4'd2,
    A_DADDR  = 4'd3,
    D_DADDR  = 4'd4,
    A_SIZE   = 4'd5,
    D_SIZE   = 4'd6,
    A_CTRL   = 4'd7,
    D_CTRL   = 4'd8,
    CHECK    = 4'd9,
    BUSY     = 4'd10,
    DONE     = 4'd11,
    WAIT_REL = 4'd12
  } state_t;

  state_t state, state_nxt;
  logic   serve_p2;
  logic   hresp_err;

`ifdef DMAC_CTRL_HRESP_ABORT_EN
  assign hresp_err = (M_HResp == HRESP_ERROR);
`else
  logic hresp_unused;
  assign hresp_unused = ^M_HResp;
  assign hresp_err    = 1'b0;
`endif

  // State register; the served peripheral is captured on leaving IDLE (bit1 wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      serve_p2 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && DmacReq != 2'b00) serve_p2 <= DmacReq[1];
    end
  end

  // Next state and decoded outputs; register enables in D states are Mealy on HReady.
  always_comb begin
    state_nxt       = state;
    DmacReq_Reg_en  = 1'b0;
    SAddr_Reg_en    = 1'b0;
    DAddr_Reg_en    = 1'b0;
    Trans_sz_Reg_en = 1'b0;
    Ctrl_Reg_en     = 1'b0;
    addr_inc_sel    = OFS_DADDR;
    config_HTrans   = HTRANS_IDLE;
    config_write    = 1'b0;
    con_en          = (state != IDLE);
    con_sel         = SEL_CFG;
    channel_en_1    = 1'b0;
    channel_en_2    = 1'b0;
    bus_req         = 1'b0;
    dmac_ack        = 2'b00;
    busy            = (state != IDLE);
    cfg_err         = 1'b0;

    case (state)
      IDLE: begin
        if (DmacReq != 2'b00) state_nxt = LATCH;
      end
      LATCH: begin
        DmacReq_Reg_en = 1'b1;
        SAddr_Reg_en   = 1'b1;
        state_nxt      = GNT_WAIT;
      end
      GNT_WAIT: begin
        bus_req = 1'b1;
        if (bus_grant) state_nxt = A_DADDR;
      end
      A_DADDR: begin
        bus_req       = 1'b1;
        config_HTrans = HTRANS_NONSEQ;
        addr_inc_sel  = OFS_DADDR;
        if (HReady && bus_grant) state_nxt = D_DADDR;
      end
      D_DADDR: begin
        bus_req      = 1'b1;
        addr_inc_sel = OFS_DADDR;
        if (HReady) begin
          if (hresp_err) begin
            cfg_err   = 1'b1;
            state_nxt = DONE;
          end else begin
            DAddr_Reg_en = 1'b1;
            state_nxt    = A_SIZE;
          end
        end
      end
      A_SIZE: begin
        bus_req       = 1'b1;
        config_HTrans = HTRANS_NONSEQ;
        addr_inc_sel  = OFS_SIZE;
        if (HReady && bus_grant) state_nxt = D_SIZE;
      end
      D_SIZE: begin
        bus_req      = 1'b1;
        addr_inc_sel = OFS_SIZE;
        if (HReady) begin
          if (hresp_err) begin
            cfg_err   = 1'b1;
            state_nxt = DONE;
          end else begin
            Trans_sz_Reg_en = 1'b1;
            state_nxt       = A_CTRL;
          end
        end
      end
      A_CTRL: begin
        bus_req       = 1'b1;
        config_HTrans = HTRANS_NONSEQ;
        addr_inc_sel  = OFS_CTRL;
        if (HReady && bus_grant) state_nxt = D_CTRL;
      end
      D_CTRL: begin
        bus_req      = 1'b1;
        addr_inc_sel = OFS_CTRL;
        if (HReady) begin
          if (hresp_err) begin
            cfg_err   = 1'b1;
            state_nxt = DONE;
          end else begin
            Ctrl_Reg_en = 1'b1;
            state_nxt   = CHECK;
          end
        end
      end
      CHECK: begin
        bus_req = 1'b1;
        if (C_config) begin
          state_nxt = BUSY;
        end else begin
          cfg_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      BUSY: begin
        bus_req      = 1'b1;
        con_sel      = serve_p2 ? SEL_CH2 : SEL_CH1;
        channel_en_1 = !serve_p2;
        channel_en_2 = serve_p2;
        if (irq) state_nxt = DONE;
      end
      DONE: begin
        dmac_ack  = serve_p2 ? 2'b10 : 2'b01;
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        // Wait for the served request level to drop so it cannot retrigger.
        if (!(serve_p2 ? DmacReq[1] : DmacReq[0])) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmac_ctrl_fsm.sv
// Scoreboard bench for dmac_ctrl_fsm: a transaction-level model schedules per-cycle inputs
// and the expected output vector of every non-idle cycle; a negedge monitor checks them.
module tb_dmac_ctrl_fsm;

  localparam logic [1:0] NONSEQ = 2'b10;
`ifdef DMAC_CTRL_HRESP_ABORT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] en;       // {DmacReq, SAddr, DAddr, Trans_sz, Ctrl}
    logic [1:0] htrans;
    logic [1:0] ais;
    logic [1:0] con_sel;
    logic       con_en;
    logic [1:0] ch;       // {channel_en_2, channel_en_1}
    logic       bus_req;
    logic [1:0] ack;
    logic       busy;
    logic       cfg_err;
    logic       cfg_write;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  typedef struct packed {
    logic [1:0] dreq;
    logic       hready;
    logic [1:0] hresp;
    logic       grant;
    logic       cconf;
    logic       irq;
  } in_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] DmacReq;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       bus_grant;
  logic       C_config;
  logic       irq;
  logic       DmacReq_Reg_en, SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en;
  logic [1:0] addr_inc_sel;
  logic [1:0] config_HTrans;
  logic       config_write;
  logic       con_en;
  logic [1:0] con_sel;
  logic       channel_en_1, channel_en_2;
  logic       bus_req;
  logic [1:0] dmac_ack;
  logic       busy;
  logic       cfg_err;

  dmac_ctrl_fsm dut (
    .clk(clk), .rst(rst), .DmacReq(DmacReq), .HReady(HReady), .M_HResp(M_HResp),
    .bus_grant(bus_grant), .C_config(C_config), .irq(irq),
    .DmacReq_Reg_en(DmacReq_Reg_en), .SAddr_Reg_en(SAddr_Reg_en), .DAddr_Reg_en(DAddr_Reg_en),
    .Trans_sz_Reg_en(Trans_sz_Reg_en), .Ctrl_Reg_en(Ctrl_Reg_en), .addr_inc_sel(addr_inc_sel),
    .config_HTrans(config_HTrans), .config_write(config_write), .con_en(con_en),
    .con_sel(con_sel), .channel_en_1(channel_en_1), .channel_en_2(channel_en_2),
    .bus_req(bus_req), .dmac_ack(dmac_ack), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  in_t  in_q[$];
  int   c0;
  int   lim;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.con_sel = 2'b10;
    return o;
  endfunction

  function automatic obs_t busy_obs();
    obs_t o = idle_obs();
    o.con_en = 1'b1;
    o.busy   = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.en        = {DmacReq_Reg_en, SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en};
    o.htrans    = config_HTrans;
    o.ais       = addr_inc_sel;
    o.con_sel   = con_sel;
    o.con_en    = con_en;
    o.ch        = {channel_en_2, channel_en_1};
    o.bus_req   = bus_req;
    o.ack       = dmac_ack;
    o.busy      = busy;
    o.cfg_err   = cfg_err;
    o.cfg_write = config_write;
    return o;
  endfunction

  function automatic logic [1:0] rnd2();
    return 2'($urandom);
  endfunction

  function automatic in_t rnd_in(input logic [1:0] dreq);
    in_t i;
    i.dreq   = dreq;
    i.hready = 1'($urandom);
    i.hresp  = 2'($urandom);
    i.grant  = 1'($urandom);
    i.cconf  = 1'($urandom);
    i.irq    = 1'($urandom);
    return i;
  endfunction

  task automatic apply(input in_t i);
    DmacReq   = i.dreq;
    HReady    = i.hready;
    M_HResp   = i.hresp;
    bus_grant = i.grant;
    C_config  = i.cconf;
    irq       = i.irq;
  endtask

  // One scheduled cycle: its inputs, and the expected outputs if the cycle is not idle.
  task automatic step(input in_t ci, input bit has_ev, input obs_t ev);
    int c;
    c = c0 + in_q.size();
    in_q.push_back(ci);
    if (has_ev && c < lim) exp_q.push_back('{cyc: c, v: ev});
  endtask

  // Plans one request end to end from phase lengths, then drives it (stopping at cut if >= 0).
  task automatic run_txn(input logic [1:0] req, input bit zw, input int irq_dly,
                         input int cconf_f, input int cut);
    in_t  ci;
    obs_t ev;
    bit   ch2, aborted, armed;
    int   n, r;
    in_q.delete();
    c0      = cyc;
    lim     = (cut < 0) ? 32'h7fff_ffff : cyc + cut;
    ch2     = req[1];
    aborted = 1'b0;
    armed   = 1'b0;

    step(rnd_in(req), 1'b0, idle_obs());
    ev = busy_obs(); ev.en = 5'b11000;
    step(rnd_in(rnd2()), 1'b1, ev);
    do begin
      ci = rnd_in(rnd2());
      if (zw) ci.grant = 1'b1;
      ev = busy_obs(); ev.bus_req = 1'b1;
      step(ci, 1'b1, ev);
    end while (!ci.grant);

    for (int w = 0; w < 3 && !aborted; w++) begin
      do begin
        ci = rnd_in(rnd2());
        if (zw) begin ci.hready = 1'b1; ci.grant = 1'b1; end
        ev = busy_obs(); ev.bus_req = 1'b1; ev.htrans = NONSEQ; ev.ais = 2'(w);
        step(ci, 1'b1, ev);
      end while (!(ci.hready && ci.grant));
      do begin
        ci = rnd_in(rnd2());
        if (zw) ci.hready = 1'b1;
        ev = busy_obs(); ev.bus_req = 1'b1; ev.ais = 2'(w);
        if (ci.hready) begin
          if (AbortEn && ci.hresp == 2'b01) begin
            ev.cfg_err = 1'b1;
            aborted    = 1'b1;
          end else begin
            ev.en = 5'b00100 >> w;
          end
        end
        step(ci, 1'b1, ev);
      end while (!ci.hready);
    end

    if (!aborted) begin
      ci = rnd_in(rnd2());
      if (cconf_f >= 0) ci.cconf = 1'(cconf_f);
      ev = busy_obs(); ev.bus_req = 1'b1; ev.cfg_err = !ci.cconf;
      step(ci, 1'b1, ev);
      armed = ci.cconf;
    end

    if (armed) begin
      n = 0;
      do begin
        ci = rnd_in(rnd2());
        ci.irq = (irq_dly >= 0) ? (n == irq_dly) : ($urandom_range(5) == 0);
        ev = busy_obs(); ev.bus_req = 1'b1;
        ev.con_sel = ch2 ? 2'b01 : 2'b00;
        ev.ch      = ch2 ? 2'b10 : 2'b01;
        step(ci, 1'b1, ev);
        n++;
      end while (!ci.irq);
    end

    ev = busy_obs(); ev.ack = ch2 ? 2'b10 : 2'b01;
    step(rnd_in(rnd2()), 1'b1, ev);

    r = $urandom_range(3);
    for (int k = 0; k < r; k++)
      step(rnd_in(ch2 ? {1'b1, 1'($urandom)} : {1'($urandom), 1'b1}), 1'b1, busy_obs());
    step(rnd_in(ch2 ? {1'b0, 1'($urandom)} : {1'($urandom), 1'b0}), 1'b1, busy_obs());
    step(rnd_in(2'b00), 1'b0, idle_obs());

    for (int k = 0; k < in_q.size(); k++) begin
      if (c0 + k >= lim) break;
      apply(in_q[k]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string name);
    obs_t o;
    o = sample();
    n_cmp++;
    if (o !== idle_obs()) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, o, idle_obs());
    end
  endtask

  // Monitor: every non-idle output vector must match the scheduled expectation for that cycle.
  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    if (rst && mon_en) begin
      o = sample();
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missed_event cyc=%0d got=idle required=%h", exp_q[0].cyc, exp_q[0].v);
        exp_q.delete(0);
      end
      if (o !== idle_obs()) begin
        n_cmp++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q[0];
          exp_q.delete(0);
          if (e.v !== o) begin
            n_err++;
            $display("FAIL event cyc=%0d got=%h required=%h", cyc, o, e.v);
          end
        end else begin
          n_err++;
          $display("FAIL unexpected_event cyc=%0d got=%h required=%h", cyc, o, idle_obs());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    apply('0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_outputs");
    rst    = 1'b1;
    mon_en = 1'b1;

    run_txn(2'b01, 1'b1, 19, 1, -1);
    run_txn(2'b11, 1'b1, 5, 1, -1);
    run_txn(2'b10, 1'b1, 3, 0, -1);
    for (int t = 0; t < 40; t++)
      run_txn(2'($urandom_range(3, 1)), 1'b0, -1, -1, -1);

    run_txn(2'b01, 1'b1, 25, 1, 15);
    DmacReq = 2'b01;
    rst     = 1'b0;
    #2;
    check_reset("reset_in_busy");
    @(posedge clk);
    #1;
    check_reset("reset_held");
    rst = 1'b1;
    run_txn(2'b01, 1'b0, -1, -1, -1);

    apply('0);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
